// File: rtl/fetch_redirect_ctrl_if.sv
`default_nettype none
// ============================================================================
// fetch_redirect_ctrl_if : fetch-stage redirect controller signal bundle
// Revision: 1.0
// ============================================================================
interface fetch_redirect_ctrl_if #(
   parameter int WORD_LEN = 32
);
   logic                bp_enable_i;
   logic                freeze_i;
   logic                if_is_branch_i;
   logic                predict_taken_i;
   logic [WORD_LEN-1:0] if_pc_i;
   logic                branch_resolved_i;
   logic                actual_taken_i;
   logic [WORD_LEN-1:0] resolved_pc_i;
   logic [1:0]          pc_sel_o;
   logic                pc_we_o;
   logic                flush_ifid_o;
   logic                bp_update_en_o;
   logic                mispredict_o;
   logic                track_full_o;
   logic                track_err_o;
   logic [31:0]         mispredict_cnt_o;
   logic [31:0]         redirect_cycles_o;

   modport master (
      output bp_enable_i, freeze_i, if_is_branch_i, predict_taken_i, if_pc_i,
             branch_resolved_i, actual_taken_i, resolved_pc_i,
      input  pc_sel_o, pc_we_o, flush_ifid_o, bp_update_en_o, mispredict_o,
             track_full_o, track_err_o, mispredict_cnt_o, redirect_cycles_o
   );

   modport slave (
      input  bp_enable_i, freeze_i, if_is_branch_i, predict_taken_i, if_pc_i,
             branch_resolved_i, actual_taken_i, resolved_pc_i,
      output pc_sel_o, pc_we_o, flush_ifid_o, bp_update_en_o, mispredict_o,
             track_full_o, track_err_o, mispredict_cnt_o, redirect_cycles_o
   );
endinterface
`default_nettype wire

// File: rtl/fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// fetch_redirect_ctrl : PC source / write-enable / IF-ID flush sequencing
// Revision: 1.0
// ============================================================================
module fetch_redirect_ctrl #(
   parameter int WORD_LEN      = 32,
   parameter int DEPTH         = 4,
   parameter int REFILL_CYCLES = 1
) (
   input logic                 clk,
   input logic                 rst_n,
   fetch_redirect_ctrl_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int RW = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;
   localparam logic [RW-1:0] REFILL_LOAD = (REFILL_CYCLES > 0) ? RW'(REFILL_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      S_BOOT   = 2'd0,
      S_RUN    = 2'd1,
      S_REFILL = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [RW-1:0]       refill_q, refill_d;
   logic [PW-1:0]       head_q, tail_q;
   logic [CW-1:0]       cnt_q;
   logic [WORD_LEN-1:0] pc_q   [DEPTH];
   logic                pred_q [DEPTH];
   logic                err_q;
   logic [31:0]         mis_cnt_q, red_cnt_q;

   logic       pred_eff, empty, full, head_hit, head_pred;
   logic       push, pop, clear, err_set, red_inc;
   logic [1:0] pc_sel;
   logic       pc_we, flush, bp_upd, mis;

   assign empty     = (cnt_q == '0);
   assign full      = (cnt_q == CW'(DEPTH));
   assign pred_eff  = bus.bp_enable_i & bus.if_is_branch_i & bus.predict_taken_i;
   // A resolve that misses the queue head is treated as predicted not-taken.
   assign head_hit  = ~empty && (pc_q[head_q] == bus.resolved_pc_i);
   assign head_pred = head_hit & pred_q[head_q];

   always_comb begin
      state_d  = state_q;
      refill_d = refill_q;
      pc_sel   = 2'b00;
      pc_we    = 1'b0;
      flush    = 1'b0;
      bp_upd   = 1'b0;
      mis      = 1'b0;
      push     = 1'b0;
      pop      = 1'b0;
      clear    = 1'b0;
      err_set  = 1'b0;
      red_inc  = 1'b0;
      unique case (state_q)
         S_BOOT: state_d = S_RUN;
         S_RUN: begin
            if (bus.branch_resolved_i) begin
               bp_upd  = bus.bp_enable_i;
               err_set = ~head_hit;
               pop     = ~empty;
            end
            if (bus.branch_resolved_i && (head_pred != bus.actual_taken_i)) begin
               mis     = 1'b1;
               flush   = 1'b1;
               pc_we   = 1'b1;
               pc_sel  = bus.actual_taken_i ? 2'b10 : 2'b11;
               clear   = 1'b1;
               red_inc = 1'b1;
               if (REFILL_CYCLES > 0) begin
                  state_d  = S_REFILL;
                  refill_d = REFILL_LOAD;
               end
            end else begin
               // A same-cycle pop frees a slot, so a full queue need not stall.
               pc_we  = ~(bus.freeze_i | (bus.if_is_branch_i & full & ~pop));
               pc_sel = (pred_eff & pc_we) ? 2'b01 : 2'b00;
               push   = pc_we & bus.if_is_branch_i;
            end
         end
         S_REFILL: begin
            flush   = 1'b1;
            red_inc = 1'b1;
            if (refill_q == '0) state_d = S_RUN;
            else                refill_d = refill_q - 1'b1;
         end
         default: state_d = S_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_BOOT;
         refill_q  <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         mis_cnt_q <= '0;
         red_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         refill_q <= refill_d;
         if (clear) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
         end else begin
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
         end
         if (err_set) err_q <= 1'b1;
         if (mis && (mis_cnt_q != '1))     mis_cnt_q <= mis_cnt_q + 1'b1;
         if (red_inc && (red_cnt_q != '1)) red_cnt_q <= red_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_q[tail_q]   <= bus.if_pc_i;
         pred_q[tail_q] <= pred_eff;
      end
   end

   assign bus.pc_sel_o          = pc_sel;
   assign bus.pc_we_o           = pc_we;
   assign bus.flush_ifid_o      = flush;
   assign bus.bp_update_en_o    = bp_upd;
   assign bus.mispredict_o      = mis;
   assign bus.track_full_o      = full;
   assign bus.track_err_o       = err_q;
   assign bus.mispredict_cnt_o  = mis_cnt_q;
   assign bus.redirect_cycles_o = red_cnt_q;
endmodule
`default_nettype wire

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
Sequencing controller for the branch-predicting fetch stage. It decides PC source, PC write enable and IF/ID flush every cycle. It tracks in-flight predicted branches in a small queue, detects mispredictions when branches resolve in ID, and schedules redirect/refill. It sits between the hazard unit, branch predictor, ID-stage branch logic and the IF-stage PC mux.

Parameters:
WORD_LEN, 32, PC/address width
DEPTH, 4, tracking-queue entries (power of 2, >=2)
REFILL_CYCLES, 1, fetch-suppress cycles after a redirect (0 allowed)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
bp_enable  in  1  prediction enable; 0 = predict not-taken always
freeze  in  1  hazard stall request
if_is_branch  in  1  predecode: IF instruction is a branch
predict_taken  in  1  predictor output for if_pc
if_pc  in  WORD_LEN  PC of IF instruction
branch_resolved  in  1  ID resolves a branch this cycle (pre-qualified by caller)
actual_taken  in  1  resolved outcome
resolved_pc  in  WORD_LEN  PC of resolved branch
pc_sel  out  2  00 PC+4, 01 if_pc+offset (predicted), 10 resolved_pc+offset, 11 resolved_pc+4
pc_we  out  1  PC register write enable
flush_ifid  out  1  squash IF/ID register
bp_update_en  out  1  train predictor
mispredict  out  1  misprediction this cycle
track_full  out  1  queue full
track_err  out  1  sticky: resolve on empty queue or PC mismatch
mispredict_cnt  out  32  saturating count
redirect_cycles  out  32  saturating count of cycles in REFILL plus redirect cycles

Behaviour:
- FSM states are BOOT, RUN and REFILL. Reset puts the FSM in BOOT, empties the queue, and clears counters and track_err. While in reset, all outputs are 0.
- BOOT: pc_we=0 for exactly one cycle, then RUN.
- pred_eff = bp_enable & if_is_branch & predict_taken.
- Fetch stall (RUN, no mispredict): stall = freeze | (if_is_branch & track_full & no pop this cycle).
- Fetch issue: pc_we = ~stall. pc_sel = 01 if pred_eff & pc_we, else 00.
- Push: on pc_we & if_is_branch in RUN, push {if_pc, pred_eff}.
- Resolve in RUN: the head entry is compared with actual_taken. The queue pops on every resolve.
  - Empty queue or head.pc != resolved_pc: set track_err and treat head.pred as 0.
- bp_update_en = branch_resolved & bp_enable in RUN. It is combinational, same cycle.
- Mispredict (head.pred != actual_taken), same cycle:
  - mispredict=1, flush_ifid=1, pc_we=1 (overrides freeze and track_full).
  - pc_sel=10 if actual_taken, else 11.
  - No push this cycle. The whole queue is cleared at the edge (younger entries squashed).
  - mispredict_cnt increments.
  - Next state is REFILL if REFILL_CYCLES>0, else RUN.
- REFILL: pc_we=0, flush_ifid=1, pc_sel=00. A down-counter loaded with REFILL_CYCLES-1 returns to RUN when it reaches 0. branch_resolved is ignored (no pop, no update).
- With bp_enable=0, every taken branch mispredicts. This gives classic resolve-in-ID behaviour with a one-bubble flush.
- Simultaneous push and pop: count unchanged; the pop frees a slot, so a full queue does not stall.
- Queue pointers wrap modulo DEPTH. Count is held in a width sufficient for 0..DEPTH. track_full = (count==DEPTH).
- Counters saturate at 0xFFFFFFFF and never wrap.
- Reset asserted mid-REFILL or mid-stall returns to BOOT immediately (asynchronous). No stale queue entries survive.
- All outputs except counters, track_full and track_err are combinational from state, queue head and inputs. There is no added latency.

Test Plan:
- Reset release: rst low→high → one cycle pc_we=0, then pc_we=1, pc_sel=00, all counters 0.
- Correct taken prediction: bp_enable=1, branch at 0x10 with predict_taken=1 → pc_sel=01. Later resolve (resolved_pc=0x10, actual_taken=1) → bp_update_en=1, mispredict=0, queue empty.
- Mispredict not-taken: branch at 0x20 predicted taken, resolve actual_taken=0 → same cycle pc_sel=11, flush_ifid=1, pc_we=1 with freeze=1. Then 1 REFILL cycle with pc_we=0. mispredict_cnt=1.
- Queue full: 4 predicted branches with no resolves, fifth branch in IF → track_full=1, pc_we=0. A resolve in the same cycle → pc_we=1 and count stays at 4.
- bp_enable=0: branch with predict_taken=1 → pc_sel=00. Resolve taken → pc_sel=10, mispredict=1, bp_update_en=0.
- Error path: branch_resolved with empty queue → track_err=1 (sticky until reset). resolved_pc mismatch on a non-empty queue → track_err=1, pop occurs.
